// File: rtl/mem_responder.sv
// Single-port word memory that answers one read or write request at a time
// after a fixed LATENCY, flagging misaligned, out-of-range and conflicting requests.
module mem_responder #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               err_c;
    logic               we_c;

    logic [31:0]        mem_q [DEPTH];

    // Next-state, request capture and registered response outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        readdata_d = '0;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        err_c      = 1'b0;
        we_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (req && (MemRead || MemWrite)) begin
                    addr_d  = addr;
                    wdata_d = writedata;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the post-edge view so they line up with state_q
        err_c   = (addr_d[1:0] != 2'b00) || (addr_d[31:2] >= 30'(DEPTH)) || (rd_d && wr_d);
        ready_d = (state_d == RESP);
        busy_d  = (state_d != IDLE);
        err_d   = ready_d && err_c;
        if (ready_d && rd_d && !err_c) begin
            readdata_d = mem_q[addr_d[AW+1:2]];
        end

        we_c = (state_q == RESP) && wr_q && !err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            readdata_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            readdata_q <= readdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Storage is never cleared; writes commit at the edge closing RESP
    always_ff @(posedge clk) begin
        if (!reset && we_c) begin
            mem_q[addr_q[AW+1:2]] <= wdata_q;
        end
    end

    assign readdata = readdata_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance at LATENCY=3, one at LATENCY=1.
module tb_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int LAT0 = 3;
    localparam int LAT1 = 1;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i   [2];
    logic        rd_i    [2];
    logic        wr_i    [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];
    logic [31:0] rdata_o [2];
    logic        ready_o [2];
    logic        busy_o  [2];
    logic        err_o   [2];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   armed = 1'b0;
    exp_t sb0 [$];
    exp_t sb1 [$];
    logic [31:0] model [2][DEPTH];

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT0)) dut0 (
        .clk(clk), .reset(reset), .req(req_i[0]), .MemRead(rd_i[0]), .MemWrite(wr_i[0]),
        .addr(addr_i[0]), .writedata(wdata_i[0]), .readdata(rdata_o[0]),
        .ready(ready_o[0]), .busy(busy_o[0]), .err(err_o[0])
    );

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
        .clk(clk), .reset(reset), .req(req_i[1]), .MemRead(rd_i[1]), .MemWrite(wr_i[1]),
        .addr(addr_i[1]), .writedata(wdata_i[1]), .readdata(rdata_o[1]),
        .ready(ready_o[1]), .busy(busy_o[1]), .err(err_o[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    // Response monitor: pop on ready, otherwise data/err must be quiet
    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                if (ready_o[d]) begin
                    if (qsize(d) == 0) begin
                        check($sformatf("spurious_ready_%0d", d), 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        if (d == 0) e = sb0.pop_front();
                        else        e = sb1.pop_front();
                        check({e.tag, "_lat"},  32'(cyc), 32'(e.due));
                        check({e.tag, "_data"}, rdata_o[d], e.data);
                        check({e.tag, "_err"},  32'(err_o[d]), 32'(e.err));
                    end
                end else begin
                    check($sformatf("quiet_rdata_%0d", d), rdata_o[d], 32'd0);
                    check($sformatf("quiet_err_%0d", d), 32'(err_o[d]), 32'd0);
                end
            end
        end
    end

    // Drive one request; returns just after the accepting edge
    task automatic xact(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input string tag, input bit expect_resp);
        exp_t e;
        logic bad;
        int   lat;
        lat = (d == 0) ? LAT0 : LAT1;
        @(negedge clk);
        req_i[d] = 1'b1; rd_i[d] = r; wr_i[d] = w; addr_i[d] = a; wdata_i[d] = wd;
        @(posedge clk);
        #1;
        req_i[d] = 1'b0; rd_i[d] = 1'b0; wr_i[d] = 1'b0;
        if (expect_resp) begin
            bad    = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH)) || (r && w);
            e.due  = cyc + lat - 1;
            e.err  = bad;
            e.data = (r && !bad) ? model[d][a[7:2]] : 32'd0;
            e.tag  = tag;
            if (w && !bad) model[d][a[7:2]] = wd;
            if (d == 0) sb0.push_back(e);
            else        sb1.push_back(e);
        end
    endtask

    task automatic wait_done(input int d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy_o[d] && qsize(d) == 0) return;
        end
        check($sformatf("timeout_%0d", d), 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        logic [31:0] a;
        logic [31:0] ra [4];
        for (int d = 0; d < 2; d++) begin
            req_i[d] = 1'b0; rd_i[d] = 1'b0; wr_i[d] = 1'b0;
            addr_i[d] = '0; wdata_i[d] = '0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_ready_%0d", d), 32'(ready_o[d]), 32'd0);
            check($sformatf("rst_busy_%0d", d),  32'(busy_o[d]),  32'd0);
            check($sformatf("rst_err_%0d", d),   32'(err_o[d]),   32'd0);
            check($sformatf("rst_rdata_%0d", d), rdata_o[d],      32'd0);
        end
        armed = 1'b1;

        xact(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10", 1'b1);      wait_done(0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd10", 1'b1);             wait_done(0);
        xact(0, 1'b0, 1'b1, 32'h13, 32'h55555555, "wr13_mis", 1'b1);  wait_done(0);
        xact(0, 1'b1, 1'b0, 32'h10, 32'h0, "rd10_after_mis", 1'b1);   wait_done(0);
        xact(0, 1'b1, 1'b0, 32'h100, 32'h0, "rd100_oor", 1'b1);       wait_done(0);
        xact(0, 1'b0, 1'b1, 32'h100, 32'h77777777, "wr100_oor", 1'b1); wait_done(0);

        // Request with neither qualifier is dropped
        @(negedge clk);
        req_i[0] = 1'b1; addr_i[0] = 32'h10;
        @(posedge clk);
        #1;
        req_i[0] = 1'b0;
        check("noqual_busy", 32'(busy_o[0]), 32'd0);

        // Held request: back-to-back reads with a single idle cycle between
        @(negedge clk);
        req_i[0] = 1'b1; rd_i[0] = 1'b1; addr_i[0] = 32'h10;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.due  = cyc + k * (LAT0 + 1) + LAT0 - 1;
            e.data = model[0][4];
            e.err  = 1'b0;
            e.tag  = $sformatf("hold_rd%0d", k);
            sb0.push_back(e);
        end
        low = 0;
        for (int i = 0; i < 3 * (LAT0 + 1); i++) begin
            @(negedge clk);
            if (!busy_o[0]) low++;
            if (i == 3 * (LAT0 + 1) - 1) begin
                req_i[0] = 1'b0; rd_i[0] = 1'b0;
            end
        end
        check("hold_busy_low_cycles", 32'(low), 32'd3);
        wait_done(0);

        // Reset one cycle into a write aborts it
        xact(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "wr20", 1'b1);      wait_done(0);
        xact(0, 1'b0, 1'b1, 32'h20, 32'h12345678, "wr20_abort", 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy_o[0]), 32'd0);
        check("abort_ready", 32'(ready_o[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT0 + 1) @(negedge clk);
        xact(0, 1'b1, 1'b0, 32'h20, 32'h0, "rd20_after_abort", 1'b1); wait_done(0);

        // Random aligned in-range write/read-back
        for (int i = 0; i < 4; i++) begin
            ra[i] = {24'd0, 6'($urandom_range(DEPTH - 1)), 2'b00};
            xact(0, 1'b0, 1'b1, ra[i], $urandom, $sformatf("rnd_wr%0d", i), 1'b1); wait_done(0);
        end
        for (int i = 0; i < 4; i++) begin
            a = ra[i];
            xact(0, 1'b1, 1'b0, a, 32'h0, $sformatf("rnd_rd%0d", i), 1'b1); wait_done(0);
        end

        // LATENCY=1 instance: conflict must not disturb word 0
        xact(1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, "l1_wr0", 1'b1);     wait_done(1);
        xact(1, 1'b1, 1'b1, 32'h0, 32'hFFFFFFFF, "l1_conflict", 1'b1); wait_done(1);
        xact(1, 1'b1, 1'b0, 32'h0, 32'h0, "l1_rd0", 1'b1);            wait_done(1);
        xact(1, 1'b1, 1'b0, 32'h3, 32'h0, "l1_rd_mis", 1'b1);         wait_done(1);

        repeat (3) @(negedge clk);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
